// File: rtl/relu_output_writer_pkg.sv
// Shared constants and types for the convolution pipeline's output-SRAM writer stage.
// SRAM geometry is reused by every stage that talks to an output SRAM.
package relu_output_writer_pkg;

    localparam int SRAM_ADDRW = 12;
    localparam int SRAM_DATAW = 16;

    typedef enum logic {
        EMPTY = 1'b0,
        HALF  = 1'b1
    } writer_state_t;

endpackage

// File: rtl/relu_output_writer.sv
// Packs pairs of 8-bit ReLU results into 16-bit words and writes them to
// sequential output-SRAM addresses, one word per matrix boundary or pair.
module relu_output_writer
    import relu_output_writer_pkg::*;
#(
    parameter int               ADDRW     = SRAM_ADDRW,
    parameter int               DATAW     = SRAM_DATAW,
    parameter logic [ADDRW-1:0] BASE_ADDR = '0
) (
    input  logic             clk,
    input  logic             reset_b,
    input  logic             start,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    input  logic             in_last,
    output logic             output_sram_write_enable,
    output logic [ADDRW-1:0] output_sram_write_addresss,
    output logic [DATAW-1:0] output_sram_write_data,
    output logic             matrix_done,
    output logic             byte_pending,
    output logic [ADDRW-1:0] words_written
);

    writer_state_t    state_q, state_d;
    logic [7:0]       held_q, held_d;
    logic [ADDRW-1:0] ptr_q;
    logic [ADDRW-1:0] addr_q;
    logic [ADDRW-1:0] cnt_q;
    logic [DATAW-1:0] data_q;
    logic             we_q;
    logic             done_q;

    logic             wr_issue;
    logic             wr_done;
    logic [DATAW-1:0] wr_word;

    always_comb begin
        state_d  = state_q;
        held_d   = held_q;
        wr_issue = 1'b0;
        wr_done  = 1'b0;
        wr_word  = data_q;
        if (start) begin
            // start outranks any same-cycle input sample
            state_d = EMPTY;
            held_d  = 8'h00;
        end else if (in_valid) begin
            case (state_q)
                EMPTY: begin
                    if (in_last) begin
                        wr_issue = 1'b1;
                        wr_done  = 1'b1;
                        wr_word  = {{(DATAW-8){1'b0}}, in_data};
                    end else begin
                        held_d  = in_data;
                        state_d = HALF;
                    end
                end
                HALF: begin
                    wr_issue = 1'b1;
                    wr_done  = in_last;
                    wr_word  = {in_data, held_q};
                    state_d  = EMPTY;
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state_q <= EMPTY;
            held_q  <= 8'h00;
            ptr_q   <= BASE_ADDR;
            addr_q  <= BASE_ADDR;
            cnt_q   <= '0;
            data_q  <= '0;
            we_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            held_q  <= held_d;
            we_q    <= wr_issue;
            done_q  <= wr_done;
            if (start) begin
                ptr_q  <= BASE_ADDR;
                addr_q <= BASE_ADDR;
                cnt_q  <= '0;
            end else begin
                // ptr_q is the next free location; the port shows it when idle
                addr_q <= ptr_q;
                if (wr_issue) begin
                    ptr_q  <= ptr_q + 1'b1;
                    cnt_q  <= cnt_q + 1'b1;
                    data_q <= wr_word;
                end
            end
        end
    end

    assign output_sram_write_enable   = we_q;
    assign output_sram_write_addresss = addr_q;
    assign output_sram_write_data     = data_q;
    assign matrix_done                = done_q;
    assign byte_pending               = (state_q == HALF);
    assign words_written              = cnt_q;

endmodule

// File: tb/tb_relu_output_writer.sv
// Self-checking bench for relu_output_writer: vector table, directed corner
// sequences and randomized traffic against a queue-based reference model.
module tb_relu_output_writer;

    localparam int ADDRW = 12;
    localparam int DATAW = 16;
    localparam logic [ADDRW-1:0] BASE = 12'h000;

    logic             clk;
    logic             reset_b;
    logic             start;
    logic             in_valid;
    logic [7:0]       in_data;
    logic             in_last;
    logic             we;
    logic [ADDRW-1:0] addr;
    logic [DATAW-1:0] data;
    logic             done;
    logic             pend;
    logic [ADDRW-1:0] words;

    relu_output_writer #(
        .ADDRW(ADDRW),
        .DATAW(DATAW),
        .BASE_ADDR(BASE)
    ) dut (
        .clk(clk),
        .reset_b(reset_b),
        .start(start),
        .in_valid(in_valid),
        .in_data(in_data),
        .in_last(in_last),
        .output_sram_write_enable(we),
        .output_sram_write_addresss(addr),
        .output_sram_write_data(data),
        .matrix_done(done),
        .byte_pending(pend),
        .words_written(words)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // reference model: bytes waiting for a partner, next address, word count
    logic [7:0] m_bytes[$];
    int         m_next;
    int         m_words;
    logic       e_we;
    logic       e_done;
    logic [11:0] e_addr;
    logic [15:0] e_data;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_bytes.delete();
        m_next  = BASE;
        m_words = 0;
        e_we    = 1'b0;
        e_done  = 1'b0;
        e_addr  = BASE;
        e_data  = 16'h0000;
    endtask

    task automatic model_cycle(input logic s, input logic v, input logic [7:0] d, input logic l);
        e_we   = 1'b0;
        e_done = 1'b0;
        if (s) begin
            m_bytes.delete();
            m_next  = BASE;
            m_words = 0;
            e_addr  = BASE;
        end else if (v) begin
            m_bytes.push_back(d);
            if (m_bytes.size() == 2 || l) begin
                e_we   = 1'b1;
                e_done = l;
                e_addr = 12'(m_next);
                e_data = (m_bytes.size() == 2) ? {m_bytes[1], m_bytes[0]} : {8'h00, m_bytes[0]};
                m_bytes.delete();
                m_next  = (m_next + 1) % 4096;
                m_words = (m_words + 1) % 4096;
            end else begin
                e_addr = 12'(m_next);
            end
        end else begin
            e_addr = 12'(m_next);
        end
    endtask

    task automatic compare_model(input string tag);
        chk({tag, ".we"},    32'(we),    32'(e_we));
        chk({tag, ".addr"},  32'(addr),  32'(e_addr));
        chk({tag, ".data"},  32'(data),  32'(e_data));
        chk({tag, ".done"},  32'(done),  32'(e_done));
        chk({tag, ".pend"},  32'(pend),  32'(m_bytes.size() == 1));
        chk({tag, ".words"}, 32'(words), 32'(m_words));
    endtask

    task automatic step(input logic s, input logic v, input logic [7:0] d, input logic l, input string tag);
        start    = s;
        in_valid = v;
        in_data  = d;
        in_last  = l;
        @(posedge clk);
        model_cycle(s, v, d, l);
        #1;
        compare_model(tag);
        start    = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    typedef struct {
        logic        v;
        logic [7:0]  d;
        logic        last;
        logic        we;
        logic [11:0] addr;
        logic [15:0] data;
        logic        done;
        logic        pend;
        logic [11:0] words;
    } vec_t;

    vec_t vecs[5];

    initial begin
        vecs[0] = '{1'b1, 8'h05, 1'b0, 1'b0, 12'h000, 16'h0000, 1'b0, 1'b1, 12'd0};
        vecs[1] = '{1'b1, 8'h10, 1'b0, 1'b1, 12'h000, 16'h1005, 1'b0, 1'b0, 12'd1};
        vecs[2] = '{1'b1, 8'h7F, 1'b0, 1'b0, 12'h001, 16'h1005, 1'b0, 1'b1, 12'd1};
        vecs[3] = '{1'b1, 8'h00, 1'b1, 1'b1, 12'h001, 16'h007F, 1'b1, 1'b0, 12'd2};
        vecs[4] = '{1'b0, 8'h00, 1'b0, 1'b0, 12'h002, 16'h007F, 1'b0, 1'b0, 12'd2};

        reset_b  = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        in_last  = 1'b0;
        model_reset();
        #1;
        compare_model("reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_b = 1'b1;

        // four-result matrix, straight out of reset
        for (int i = 0; i < 5; i++) begin
            step(1'b0, vecs[i].v, vecs[i].d, vecs[i].last, $sformatf("vec%0d", i));
            chk($sformatf("tbl%0d.we", i),    32'(we),    32'(vecs[i].we));
            chk($sformatf("tbl%0d.addr", i),  32'(addr),  32'(vecs[i].addr));
            chk($sformatf("tbl%0d.data", i),  32'(data),  32'(vecs[i].data));
            chk($sformatf("tbl%0d.done", i),  32'(done),  32'(vecs[i].done));
            chk($sformatf("tbl%0d.pend", i),  32'(pend),  32'(vecs[i].pend));
            chk($sformatf("tbl%0d.words", i), 32'(words), 32'(vecs[i].words));
        end

        // odd-length matrix followed by a fresh matrix
        step(1'b1, 1'b0, 8'h00, 1'b0, "odd.start");
        step(1'b0, 1'b1, 8'h01, 1'b0, "odd.01");
        step(1'b0, 1'b1, 8'h02, 1'b0, "odd.02");
        chk("odd.w0", {we, addr, data}, {1'b1, 12'h000, 16'h0201});
        step(1'b0, 1'b1, 8'h03, 1'b1, "odd.03");
        chk("odd.w1", {we, done, addr, data}, {1'b1, 1'b1, 12'h001, 16'h0003});
        step(1'b0, 1'b1, 8'h04, 1'b0, "odd.04");
        step(1'b0, 1'b1, 8'h05, 1'b1, "odd.05");
        chk("odd.w2", {we, done, addr, data}, {1'b1, 1'b1, 12'h002, 16'h0504});

        // gapped input holds the low byte across idle cycles
        step(1'b1, 1'b0, 8'h00, 1'b0, "gap.start");
        step(1'b0, 1'b1, 8'h11, 1'b0, "gap.11");
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 8'h00, 1'b1, "gap.idle");
            chk("gap.pend", {pend, we}, {1'b1, 1'b0});
        end
        step(1'b0, 1'b1, 8'h22, 1'b1, "gap.22");
        chk("gap.w", {we, done, addr, data}, {1'b1, 1'b1, 12'h000, 16'h2211});

        // start during HALF drops both the held byte and the concurrent sample
        step(1'b1, 1'b0, 8'h00, 1'b0, "sh.start0");
        step(1'b0, 1'b1, 8'h33, 1'b0, "sh.33");
        step(1'b1, 1'b1, 8'h44, 1'b0, "sh.start44");
        chk("sh.cleared", {pend, we}, {1'b0, 1'b0});
        step(1'b0, 1'b1, 8'h55, 1'b0, "sh.55");
        step(1'b0, 1'b1, 8'h66, 1'b1, "sh.66");
        chk("sh.w", {we, done, addr, data}, {1'b1, 1'b1, BASE, 16'h6655});

        // async reset mid-matrix
        step(1'b0, 1'b1, 8'h5A, 1'b0, "ar.5A");
        step(1'b0, 1'b1, 8'hA5, 1'b0, "ar.A5");
        step(1'b0, 1'b1, 8'h3C, 1'b0, "ar.3C");
        @(negedge clk);
        #2;
        reset_b = 1'b0;
        model_reset();
        #1;
        chk("ar.zero", {we, done, pend, addr, data, words}, {1'b0, 1'b0, 1'b0, BASE, 16'h0000, 12'd0});
        compare_model("ar.model");
        @(negedge clk);
        reset_b = 1'b1;
        step(1'b0, 1'b1, 8'h77, 1'b0, "ar.77");
        step(1'b0, 1'b1, 8'h88, 1'b0, "ar.88");
        chk("ar.w", {we, addr, data}, {1'b1, BASE, 16'h8877});

        // pointer and word counter wrap
        step(1'b1, 1'b0, 8'h00, 1'b0, "wr.start");
        for (int i = 0; i < 8190; i++)
            step(1'b0, 1'b1, 8'($urandom_range(0, 127)), 1'b0, "wr.fill");
        chk("wr.ptr", {addr, words}, {12'hFFE, 12'hFFF});
        step(1'b0, 1'b1, 8'h0A, 1'b0, "wr.0A");
        step(1'b0, 1'b1, 8'h0B, 1'b0, "wr.0B");
        chk("wr.top", {we, addr, data, words}, {1'b1, 12'hFFF, 16'h0B0A, 12'd0});
        step(1'b0, 1'b1, 8'h0C, 1'b0, "wr.0C");
        step(1'b0, 1'b1, 8'h0D, 1'b1, "wr.0D");
        chk("wr.zero", {we, done, addr, data, words}, {1'b1, 1'b1, 12'h000, 16'h0D0C, 12'd1});

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic s, v, l;
            s = ($urandom_range(0, 49) == 0);
            v = ($urandom_range(0, 3) != 0);
            l = ($urandom_range(0, 5) == 0);
            step(s, v, 8'($urandom), l, "rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/relu_output_writer.md
# relu_output_writer

Final stage of the convolution pipeline. It accepts the stream of 8-bit post-ReLU results, one per valid cycle, and packs consecutive pairs into 16-bit words. It writes those words to sequential output-SRAM addresses. Each matrix starts on a fresh word, and the block signals when a matrix's last word has been written.

## Interface
Parameters:
- ADDRW, 12, output SRAM address width
- DATAW, 16, output SRAM data width (two 8-bit results)
- BASE_ADDR, 12'h000, first write address after reset or `start`

Ports:
- clk  in  1  single clock, rising edge
- reset_b  in  1  reset; **asynchronous assert, active-low**
- start  in  1  one-cycle pulse at the beginning of a run; clears the pointer and any held byte
- in_valid  in  1  result on in_data is valid this cycle
- in_data  in  8  ReLU result, unsigned 0..127 (upper values are passed through unchecked)
- in_last  in  1  qualified by in_valid; marks the final result of a matrix
- output_sram_write_enable  out  1  write strobe, registered
- output_sram_write_addresss  out  ADDRW  write address, registered
- output_sram_write_data  out  DATAW  write data, registered
- matrix_done  out  1  one-cycle pulse, asserted in the same cycle as the last write of a matrix
- byte_pending  out  1  a low byte is held and awaiting its partner
- words_written  out  ADDRW  count of words written since the last start or reset

## Operation
- State machine (2 states):
  - EMPTY:
    - in_valid & ~in_last: capture in_data as the low byte, then go to HALF.
    - in_valid & in_last: issue a write of {8'h00, in_data}, stay in EMPTY, pulse matrix_done.
  - HALF:
    - in_valid: issue a write of {in_data, held}, then go to EMPTY.
    - If in_last is also set, pulse matrix_done with that write.
- Byte order: the earlier result goes in bits [7:0], the later one in bits [15:8].
- Odd-length matrix: the last word's high byte is zero-padded. The next matrix begins at the next address in EMPTY.
- Write pointer:
  - Increments by 1 after every issued write.
  - Wraps from 2^ADDRW-1 to 0 with no error.
  - words_written increments in lockstep and also wraps.
- start: forces EMPTY, sets the pointer to BASE_ADDR, zeroes words_written and drops any held byte.
  - If in_valid arrives in the same cycle, that sample is ignored.
  - start has priority over all other events.
- byte_pending is high exactly when the state is HALF.

## Timing
- Reset (async, reset_b=0), all cleared immediately:
  - write_enable=0, address=BASE_ADDR, data=16'h0000
  - matrix_done=0, byte_pending=0, words_written=0
  - state EMPTY
- Reset mid-operation discards any held byte; no write is produced.
- Latency: a write appears on the SRAM port in the cycle after the accepting in_valid edge.
  - write_enable is high for exactly one cycle per word.
  - address and data are stable for that cycle.
- Throughput: one result per cycle, sustained.
  - This gives at most one write per two input cycles, except odd-last words.
  - There is no backpressure; the block is always ready.
- While write_enable=0, address holds the next write location and data holds its last value.
- matrix_done rises in the same cycle as the write_enable carrying the matrix's final word.
- in_last without in_valid is ignored.

## Structure
- A shared package holds:
  - ADDRW and DATAW constants, reused by the SRAM interfaces of every stage
  - the writer state enum (EMPTY, HALF)
- No sub-module is needed. The design is one FSM, a byte holding register, the address counter and the word counter.

## Test plan
- Four-result matrix:
  - Stimulus: 05, 10, 7F, 00 on consecutive cycles, in_last on the 4th.
  - Expected: addr 000 = 16'h1005, addr 001 = 16'h007F; matrix_done with the second write; words_written=2.
- Odd-length matrix then a new matrix:
  - Stimulus: 01, 02, 03 with in_last on 03, then 04, 05 with in_last on 05.
  - Expected: 000=0201, 001=0003 (done), 002=0504 (done).
- Gapped input: 11, idle for 3 cycles, 22 with in_last.
  - Expected: byte_pending high during the gap; single write 000=2211, one cycle after 22; matrix_done with it.
- start during HALF:
  - Stimulus: 33 (pending), then start together with in_valid 44, then 55, 66 with in_last.
  - Expected: 44 is dropped; the first write after start is BASE_ADDR=6655.
- Wrap-around:
  - Preload the pointer to FFF via 8190 inputs, then 0A, 0B.
  - Expected: a write at FFF, then the next write at 000; words_written wraps to 0.
- Async reset mid-matrix:
  - Stimulus: assert reset_b=0 between clock edges while HALF.
  - Expected: outputs go to 0 immediately; after release, the first pair writes at BASE_ADDR with no stale byte.
